// File: rtl/sp_ram_be_clr_pkg.sv
// Shared definitions for the byte-enable single-port RAM with clear engine.
package sp_ram_pkg;

    localparam int RDW_NEW = 0;
    localparam int RDW_OLD = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int calc_nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sp_ram_be_clr_if.sv
// Request/response bundle between the ADC capture side and the RAM.
interface sp_ram_be_clr_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = sp_ram_pkg::calc_nb(DATA_WIDTH, BYTE_WIDTH);

    logic                  req;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  clr_req;
    logic                  ready;
    logic                  busy;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;

    modport master (
        output req, we, be, addr, data, clr_req,
        input  ready, busy, q, q_valid
    );

    modport slave (
        input  req, we, be, addr, data, clr_req,
        output ready, busy, q, q_valid
    );

endinterface

// File: rtl/sp_ram_clear_ctrl.sv
// Clear engine: zero-fill walker, one word per cycle, owns busy.
// Latency: clr_req sampled at edge T, addresses written at T+1..T+DEPTH.
// Backpressure: none; clr_req is ignored while already clearing.
module sp_ram_clear_ctrl
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        busy     = (state_q == ST_CLEAR);
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                // Leave on the same edge that writes the final address.
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sp_ram_be_clr.sv
// Single-port RAM with byte enables, selectable read-during-write and zero-fill engine.
// Latency: q/q_valid one edge after acceptance (two with OUT_REG=1), fully pipelined.
// Backpressure: ready=~busy; requests presented while busy are dropped without response.
module sp_ram_be_clr
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sp_ram_be_clr_if.slave       bus
);

    localparam int NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    sp_ram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy  = busy;
    assign bus.ready = ~busy;

    logic acc;
    assign acc = bus.req & ~busy;

    // clr_we only while busy and acc only while idle, so the port never collides.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdat;

    always_comb begin
        mem_we   = clr_we | (acc & bus.we);
        mem_addr = clr_we ? clr_addr : bus.addr;
        mem_be   = clr_we ? {NB{1'b1}} : bus.be;
        mem_wdat = clr_we ? '0 : bus.data;
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Read-first port: rd_q captures the pre-write word; updated only on user accesses.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (acc) begin
            rd_q <= mem[mem_addr];
        end
    end

    logic                  vld1_q, vld1_d;
    logic                  seen_q, seen_d;
    logic                  we1_q, we1_d;
    logic [NB-1:0]         be1_q, be1_d;
    logic [DATA_WIDTH-1:0] wdat1_q, wdat1_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q  <= 1'b0;
            seen_q  <= 1'b0;
            we1_q   <= 1'b0;
            be1_q   <= '0;
            wdat1_q <= '0;
        end else begin
            vld1_q  <= vld1_d;
            seen_q  <= seen_d;
            we1_q   <= we1_d;
            be1_q   <= be1_d;
            wdat1_q <= wdat1_d;
        end
    end

    always_comb begin
        vld1_d  = acc;
        seen_d  = seen_q | acc;
        we1_d   = acc ? bus.we   : we1_q;
        be1_d   = acc ? bus.be   : be1_q;
        wdat1_d = acc ? bus.data : wdat1_q;
    end

    // Merged word rebuilt from the old word so the array stays a plain RAM.
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] res1;

    always_comb begin
        merged = rd_q;
        for (int i = 0; i < NB; i++) begin
            if (be1_q[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdat1_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (!seen_q) begin
            res1 = '0;
        end else if (we1_q && (RDW_MODE == RDW_NEW)) begin
            res1 = merged;
        end else begin
            res1 = rd_q;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] q2_q, q2_d;
        logic                  vld2_q, vld2_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q2_q   <= '0;
                vld2_q <= 1'b0;
            end else begin
                q2_q   <= q2_d;
                vld2_q <= vld2_d;
            end
        end

        always_comb begin
            vld2_d = vld1_q;
            q2_d   = vld1_q ? res1 : q2_q;
        end

        assign bus.q       = q2_q;
        assign bus.q_valid = vld2_q;
    end else begin : g_noreg
        assign bus.q       = res1;
        assign bus.q_valid = vld1_q;
    end

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Scoreboard bench: two instances (new-data/no-reg and old-data/out-reg) driven identically.
module tb_sp_ram_be_clr;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_ram_be_clr_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if0 ();
    sp_ram_be_clr_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if1 ();

    sp_ram_be_clr #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                    .OUT_REG(0), .RDW_MODE(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sp_ram_be_clr #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                    .OUT_REG(1), .RDW_MODE(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n0, n1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected response whenever a DUT presents q_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.q_valid) begin
                if (sb0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL d0_unexpected_valid: got q_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e0 = sb0.pop_front();
                    check("d0_q", if0.q, e0.d);
                    check("d0_latency_cycle", cyc, e0.c);
                end
            end
            if (if1.q_valid) begin
                if (sb1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL d1_unexpected_valid: got q_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e1 = sb1.pop_front();
                    check("d1_q", if1.q, e1.d);
                    check("d1_latency_cycle", cyc, e1.c);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [10:0] a, input logic [31:0] d, input logic cl);
        if0.req = r;  if1.req = r;
        if0.we  = w;  if1.we  = w;
        if0.be  = b;  if1.be  = b;
        if0.addr = a; if1.addr = a;
        if0.data = d; if1.data = d;
        if0.clr_req = cl; if1.clr_req = cl;
    endtask

    // One accepted access; e_new/e_old are the responses for RDW new / old instances.
    task automatic access(input logic w, input logic [3:0] b, input logic [10:0] a,
                          input logic [31:0] d, input logic [31:0] e_new,
                          input logic [31:0] e_old, input logic cl = 1'b0);
        @(negedge clk);
        drive(1'b1, w, b, a, d, cl);
        sb0.push_back('{e_new, cyc + 1});
        sb1.push_back('{e_old, cyc + 2});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!if0.busy && !if1.busy) return;
            if (if0.busy) c0++;
            if (if1.busy) c1++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL busy_timeout: got busy still 1 after 5000 cycles expected 0");
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_d0_q"},       if0.q,       32'h0);
        check({tag, "_d0_q_valid"}, if0.q_valid, 32'h0);
        check({tag, "_d0_busy"},    if0.busy,    32'h1);
        check({tag, "_d0_ready"},   if0.ready,   32'h0);
        check({tag, "_d1_q"},       if1.q,       32'h0);
        check({tag, "_d1_q_valid"}, if1.q_valid, 32'h0);
        check({tag, "_d1_busy"},    if1.busy,    32'h1);
        check({tag, "_d1_ready"},   if1.ready,   32'h0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check_rst("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(n0, n1);
        check("por_busy_cycles_d0", n0, 2048);
        check("por_busy_cycles_d1", n1, 2048);

        // Cleared array reads back zero at both ends and the middle.
        access(1'b0, 4'h0, 11'h000, 32'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 11'h3FF, 32'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 11'h7FF, 32'h0, 32'h0, 32'h0);

        // Byte-lane merge and read-during-write result.
        access(1'b1, 4'hF, 11'h010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000);
        access(1'b1, 4'h5, 11'h010, 32'h11223344, 32'hDE22BE44, 32'hDEADBEEF);
        access(1'b0, 4'h0, 11'h010, 32'h0,        32'hDE22BE44, 32'hDE22BE44);
        access(1'b1, 4'h0, 11'h010, 32'hFFFFFFFF, 32'hDE22BE44, 32'hDE22BE44);
        access(1'b0, 4'h0, 11'h010, 32'h0,        32'hDE22BE44, 32'hDE22BE44);

        // Fill, then a write alongside clr_req; requests held during the clear are dropped.
        access(1'b1, 4'hF, 11'h020, 32'h12345678, 32'h12345678, 32'h00000000);
        access(1'b1, 4'hF, 11'h030, 32'h0BADCAFE, 32'h0BADCAFE, 32'h00000000);
        access(1'b1, 4'hF, 11'h020, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678, 1'b1);
        #1 drive(1'b1, 1'b0, 4'h0, 11'h020, 32'h0, 1'b0);
        wait_idle(n0, n1);
        drive(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
        check("cmd_busy_cycles_d0", n0, 2048);
        check("cmd_busy_cycles_d1", n1, 2048);
        access(1'b0, 4'h0, 11'h020, 32'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 11'h030, 32'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 11'h010, 32'h0, 32'h0, 32'h0);

        access(1'b1, 4'hF, 11'h040, 32'hCAFEF00D, 32'hCAFEF00D, 32'h00000000);
        access(1'b0, 4'h0, 11'h040, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D);
        idle();
        repeat (3) @(negedge clk);
        check("hold_d0_q", if0.q, 32'hCAFEF00D);
        check("hold_d1_q", if1.q, 32'hCAFEF00D);

        // Reset in the middle of a commanded clear.
        if0.clr_req = 1'b1; if1.clr_req = 1'b1;
        @(negedge clk);
        if0.clr_req = 1'b0; if1.clr_req = 1'b0;
        repeat (1023) @(negedge clk);
        rst_n = 1'b0;
        #1 check_rst("mid");
        repeat (2) @(negedge clk);
        check_rst("mid_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(n0, n1);
        check("rst_busy_cycles_d0", n0, 2048);
        check("rst_busy_cycles_d1", n1, 2048);
        access(1'b0, 4'h0, 11'h040, 32'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 11'h7FF, 32'h0, 32'h0, 32'h0);
        idle();
        repeat (4) @(negedge clk);
        check("sb0_left", sb0.size(), 32'h0);
        check("sb1_left", sb1.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
